// File: rtl/stream_chan_mux.sv
// stream_chan_mux
//   N-channel valid/ready stream multiplexer. A combinational round-robin
//   arbiter picks one requesting channel per cycle. The chosen beat is tagged
//   with its channel index and lands in a main output register (M). A second
//   skid register (S) absorbs the one beat that is already in flight when
//   the downstream consumer stalls. This keeps full throughput without a
//   combinational path from out_ready to in_ready.
//
//   Optional feature, selected by the macro STREAM_MUX_PKT_LOCK_EN:
//     When the macro is defined, the grant stays on one channel from its
//     first accepted beat until a beat with in_last=1 is accepted.
//     When it is undefined, arbitration is per beat and packets may
//     interleave; out_ch tells them apart.
//
// Parameters
//   NUM_CH  number of input channels (2..16)
//   DATA_W  payload width in bits (1..512)
//   CH_W    channel tag width, derived from NUM_CH
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   per-channel beat valid             [NUM_CH]
//   in_ready   per-channel accept, one-hot or 0   [NUM_CH]
//   in_data    channel c at [c*DATA_W +: DATA_W]  [NUM_CH*DATA_W]
//   in_last    per-channel end-of-packet          [NUM_CH]
//   out_valid  output beat valid
//   out_ready  downstream accept
//   out_data   output payload                     [DATA_W]
//   out_last   end-of-packet of output beat
//   out_ch     source channel of output beat      [CH_W]
module stream_chan_mux #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch
);

  // Round-robin search. The search starts one past the last granted
  // channel and wraps at NUM_CH-1, so non-power-of-two channel counts work.
  // Result: {found, channel}.
  function automatic logic [CH_W:0] rr_pick(input logic [CH_W-1:0] start,
                                            input logic [NUM_CH-1:0] vld);
    logic [CH_W-1:0] c;
    logic [CH_W-1:0] pick;
    logic            found;
    c     = start;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
      if (!found && vld[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
    return {found, pick};
  endfunction

  logic [CH_W-1:0]   ptr;
  logic [CH_W:0]     rr_res;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              accept;
  logic              drain;

  logic [DATA_W-1:0] sel_data_p0;
  logic              sel_last_p0;

  logic              m_vld_p1;
  logic [DATA_W-1:0] m_data_p1;
  logic              m_last_p1;
  logic [CH_W-1:0]   m_ch_p1;

  logic              s_vld_p1;
  logic [DATA_W-1:0] s_data_p1;
  logic              s_last_p1;
  logic [CH_W-1:0]   s_ch_p1;

  assign rr_res = rr_pick(ptr, in_valid);

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            lock_act;
  logic [CH_W-1:0] lock_ch;

  // While a packet is open, only its channel may be granted. If that
  // channel pauses mid-packet, nobody is granted.
  always_comb begin
    if (lock_act) begin
      grant_vld = in_valid[lock_ch];
      grant_ch  = lock_ch;
    end else begin
      grant_vld = rr_res[CH_W];
      grant_ch  = rr_res[CH_W-1:0];
    end
  end
`else
  assign grant_vld = rr_res[CH_W];
  assign grant_ch  = rr_res[CH_W-1:0];
`endif

  // ---- stage p0: grant, beat selection, handshake ----
  // A full skid register blocks all intake. The stall signal therefore
  // comes from a register and never from out_ready.
  assign accept = grant_vld && !s_vld_p1 && !rst;
  assign drain  = m_vld_p1 && out_ready;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    sel_data_p0 = '0;
    sel_last_p0 = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == grant_ch) begin
        sel_data_p0 = in_data[c*DATA_W +: DATA_W];
        sel_last_p0 = in_last[c];
      end
    end
  end

  // ---- stage p1: main (M) and skid (S) registers ----
  // Data registers are cleared too, so that out_data, out_last and
  // out_ch read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_p1  <= 1'b0;
      m_data_p1 <= '0;
      m_last_p1 <= 1'b0;
      m_ch_p1   <= '0;
      s_vld_p1  <= 1'b0;
      s_data_p1 <= '0;
      s_last_p1 <= 1'b0;
      s_ch_p1   <= '0;
      ptr       <= CH_W'(NUM_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_act  <= 1'b0;
      lock_ch   <= '0;
`endif
    end else begin
      if (drain) begin
        // S holds the older beat and goes first. When S is full, accept
        // is 0, so no new beat can compete with it.
        if (s_vld_p1) begin
          m_data_p1 <= s_data_p1;
          m_last_p1 <= s_last_p1;
          m_ch_p1   <= s_ch_p1;
          s_vld_p1  <= 1'b0;
        end else if (accept) begin
          m_data_p1 <= sel_data_p0;
          m_last_p1 <= sel_last_p0;
          m_ch_p1   <= grant_ch;
        end else begin
          m_vld_p1  <= 1'b0;
        end
      end else if (accept) begin
        if (!m_vld_p1) begin
          m_vld_p1  <= 1'b1;
          m_data_p1 <= sel_data_p0;
          m_last_p1 <= sel_last_p0;
          m_ch_p1   <= grant_ch;
        end else begin
          s_vld_p1  <= 1'b1;
          s_data_p1 <= sel_data_p0;
          s_last_p1 <= sel_last_p0;
          s_ch_p1   <= grant_ch;
        end
      end

      if (accept) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (sel_last_p0) begin
          ptr      <= grant_ch;
          lock_act <= 1'b0;
        end else begin
          lock_act <= 1'b1;
          lock_ch  <= grant_ch;
        end
`else
        ptr <= grant_ch;
`endif
      end
    end
  end

  assign out_valid = m_vld_p1;
  assign out_data  = m_data_p1;
  assign out_last  = m_last_p1;
  assign out_ch    = m_ch_p1;

endmodule

// File: tb/tb_stream_chan_mux.sv
// tb_stream_chan_mux
//   Directed bench for stream_chan_mux (NUM_CH=4, DATA_W=32). It covers:
//   reset state, a single beat after reset, round-robin fairness, skid
//   behaviour under backpressure, reset with both registers full, and a
//   random valid/ready run with a per-channel scoreboard. Each beat payload
//   carries {channel, sequence}, so loss, duplication, reordering or a wrong
//   tag shows up as a data mismatch.
module tb_stream_chan_mux;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W:0] sbq [NUM_CH][$];
  bit              sb_on = 1'b0;
  int              acc_cnt = 0;
  int              pop_cnt = 0;

  stream_chan_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] beat(input int c, input int s);
    return {8'(c), 24'(s)};
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic sb_clear();
    for (int c = 0; c < NUM_CH; c++) sbq[c].delete();
    acc_cnt = 0;
    pop_cnt = 0;
  endtask

  // Handshakes are sampled at the falling edge, where inputs and outputs
  // are stable for the coming rising edge.
  always @(negedge clk) begin
    if (sb_on) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          sbq[c].push_back({in_last[c], in_data[c*DATA_W +: DATA_W]});
          acc_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sbq[int'(out_ch)].size() == 0)
          chk_val("sb_queue_nonempty", 64'(sbq[int'(out_ch)].size()), 64'd1);
        else
          chk_val("sb_beat", 64'({out_last, out_data}), 64'(sbq[int'(out_ch)].pop_front()));
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] hs;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] lst;
    int                sq [NUM_CH];
    int                seq;
    int                t;
    int                cyc;
    int                left;

    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '1;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset, then a single beat on ch2
    in_data[2*DATA_W +: DATA_W] = 32'hA5A5_0001;
    in_valid = 4'b0100;
    tick();
    chk_val("rst_in_ready",  64'(in_ready),  64'd0);
    chk_val("rst_out_valid", 64'(out_valid), 64'd0);
    chk_val("rst_out_data",  64'(out_data),  64'd0);
    chk_val("rst_out_last",  64'(out_last),  64'd0);
    chk_val("rst_out_ch",    64'(out_ch),    64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk_val("single_in_ready", 64'(in_ready), 64'b0100);
    tick();
    in_valid = '0;
    chk_val("single_out_valid", 64'(out_valid), 64'd1);
    chk_val("single_out_data",  64'(out_data),  64'hA5A5_0001);
    chk_val("single_out_ch",    64'(out_ch),    64'd2);
    chk_val("single_out_last",  64'(out_last),  64'd1);
    tick();
    chk_val("single_drained", 64'(out_valid), 64'd0);

    // Fairness: all channels request continuously
    reset_dut();
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = beat(c, 7);
    in_valid = 4'hF;
    #1;
    chk_val("fair_first_ready", 64'(in_ready), 64'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_val("fair_out_valid", 64'(out_valid), 64'd1);
      chk_val("fair_out_ch",    64'(out_ch),    64'(i % 4));
      chk_val("fair_out_data",  64'(out_data),  64'(beat(i % 4, 7)));
      chk_val("fair_in_ready",  64'(in_ready),  64'(4'b0001 << ((i + 1) % 4)));
    end
    in_valid = '0;
    tick();
    chk_val("fair_end", 64'(out_valid), 64'd0);

    // Reset with both M and S full
    reset_dut();
    out_ready = 1'b0;
    in_data[0*DATA_W +: DATA_W] = beat(0, 1);
    in_data[3*DATA_W +: DATA_W] = beat(3, 1);
    in_valid = 4'b1001;
    tick();
    tick();
    chk_val("mid_full_ready", 64'(in_ready), 64'd0);
    chk_val("mid_full_ch",    64'(out_ch),   64'd0);
    rst = 1'b1;
    tick();
    chk_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk_val("mid_rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    chk_val("mid_first_grant", 64'(in_ready), 64'b0001);
    in_valid  = '0;
    out_ready = 1'b1;
    tick();

    // Skid: stream on ch1, out_ready low for 3 cycles
    reset_dut();
    sb_clear();
    sb_on    = 1'b1;
    seq      = 0;
    t        = 0;
    in_valid = 4'b0010;
    while (seq < 20 && t < 200) begin
      out_ready = !(t >= 5 && t <= 7);
      in_data[1*DATA_W +: DATA_W] = beat(1, seq);
      in_last[1] = (seq % 5 == 4);
      #1;
      if (t == 5) chk_val("skid_extra_beat", 64'(in_ready), 64'b0010);
      if (t == 6 || t == 7 || t == 8) chk_val("skid_ready_low", 64'(in_ready), 64'd0);
      if (t == 7) begin
        chk_val("skid_hold_valid", 64'(out_valid), 64'd1);
        chk_val("skid_hold_data",  64'(out_data),  64'(beat(1, 4)));
      end
      if (t == 9) chk_val("skid_ready_back", 64'(in_ready), 64'b0010);
      hs = in_ready;
      tick();
      if (hs[1]) seq++;
      t++;
    end
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk_val("skid_accepted", 64'(acc_cnt), 64'd20);
    chk_val("skid_delivered", 64'(pop_cnt), 64'd20);
    sb_on = 1'b0;

    // Random valid/ready with per-channel scoreboard
    in_last = '1;
    reset_dut();
    sb_clear();
    sb_on = 1'b1;
    for (int c = 0; c < NUM_CH; c++) sq[c] = 0;
    vld = '0;
    lst = '0;
    hs  = '0;
    cyc = 0;
    while (acc_cnt < 3000 && cyc < 30000) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[c]) begin
          sq[c]++;
          vld[c] = 1'($urandom_range(1, 0));
          lst[c] = 1'($urandom_range(1, 0));
        end else if (!vld[c]) begin
          vld[c] = 1'($urandom_range(1, 0));
          lst[c] = 1'($urandom_range(1, 0));
        end
        in_data[c*DATA_W +: DATA_W] = beat(c, sq[c]);
      end
      in_valid  = vld;
      in_last   = lst;
      out_ready = 1'($urandom_range(1, 0));
      #1;
      chk_val("stress_onehot",   64'($onehot0(in_ready)),   64'd1);
      chk_val("stress_ready_ok", 64'(in_ready & ~in_valid), 64'd0);
      hs = in_valid & in_ready;
      tick();
      cyc++;
    end
    chk_val("stress_budget", 64'(acc_cnt >= 3000), 64'd1);
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk_val("stress_drained", 64'(pop_cnt), 64'(acc_cnt));
    left = 0;
    for (int c = 0; c < NUM_CH; c++) left += sbq[c].size();
    chk_val("stress_queues_empty", 64'(left), 64'd0);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
